sprite_blitter: RTL
===================

Name: sprite_blitter

Overview:
- Writer/RMW client for the CPU-side port of the 128x64 monochrome framebuffer: 512 x 16-bit words, addr = {row[5:0], word[2:0]}.
- Pixel x of a row lives in word x[6:4], bit 15 - x[3:0], so the leftmost pixel is the MSB.
- Executes the Chip-8/SCHIP DXYN draw: fetches sprite bytes from main memory, XORs them into the framebuffer, reports collision.
- Sits beside the CPU core and is started by the draw opcode; the CPU stalls on busy.

Parameters:
- MEM_AW, 12, main-memory byte address width.
- FB_AW, 9, framebuffer word address width; fixed by the 128x64 geometry.

Ports:
- clk  in  1  system clock; same clock as the framebuffer CPU port.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle draw request; sampled only in IDLE.
- spr_x  in  7  start column, 0..127.
- spr_y  in  6  start row, 0..63.
- spr_n  in  4  row count; 0 selects a 16x16 sprite.
- spr_i  in  MEM_AW  sprite base address (the I register).
- busy  out  1  high while drawing.
- done  out  1  one-cycle pulse at completion.
- collision  out  1  any set pixel cleared during the last draw.
- mem_addr  out  MEM_AW  sprite byte address.
- mem_rd  out  1  read strobe; mem_data is valid the next cycle.
- mem_data  in  8  sprite byte.
- fbuf_en  out  1  framebuffer port enable.
- fbuf_write  out  1  framebuffer write.
- fbuf_addr  out  FB_AW  framebuffer word address.
- fbuf_in  out  16  write data.
- fbuf_out  in  16  read data, registered, valid the cycle after fbuf_en.

Behaviour:
- Reset: state IDLE. busy, done, collision, mem_rd, fbuf_en and fbuf_write are 0; mem_addr, fbuf_addr and fbuf_in are 0.
- Reset mid-draw returns to IDLE within one cycle. Words already written stay in the framebuffer.
- Start: start in IDLE latches all inputs and clears collision; busy=1 from the next cycle. start while busy is ignored.
- Sprite shape:
  - spr_n!=0: spr_n rows, 8 bits wide, row r byte at I+r.
  - spr_n==0: 16 rows, 16 bits wide, row r bytes at I+2r (high) and I+2r+1 (low).
  - An 8-bit row is zero-extended on the right to 16 bits as {byte, 8'h00}.
- Alignment: pattern32 = {row16, 16'h0} >> x[3:0].
  - Word 0 = pattern32[31:16] at word x[6:4].
  - Word 1 = pattern32[15:0] at word x[6:4]+1.
- Clipping:
  - The start point is inherently mod 128/64.
  - If x[6:4]==7, word 1 is skipped; no horizontal wrap.
  - A row with y+r>63 ends the draw; no vertical wrap.
- FSM states: IDLE, FETCH, FWAIT, FETCH2, FWAIT2, RD0, WR0, RD1, WR1, DONE.
- Per-row state sequence:
  - FETCH: mem_rd=1.
  - FWAIT: capture mem_data.
  - FETCH2/FWAIT2: only for 16-wide rows.
  - RD0: fbuf_en=1, write=0.
  - WR0: fbuf_en=1, write=1, fbuf_in = fbuf_out ^ w0; collision |= |(fbuf_out & w0).
  - RD1/WR1: same as RD0/WR0 for word 1, unless clipped.
  - Next row, or DONE.
- DONE: done=1 and busy=0 in the same cycle, then IDLE.
- Timing: an unclipped 8-wide row takes 6 cycles, so a draw of n rows ends with done in cycle 6n+1 after start.
- collision holds its value until the next accepted start.
- fbuf_en=0 in every state except RD*/WR*. The port is read-before-write, so the WR cycle's fbuf_out is ignored.

Optional Feature:
- Macro: SPRITE_BLITTER_LORES_EN.
- Defined:
  - Extra input port lores (1 bit), latched at start.
  - When lores=1, coordinates are mod 64/32 and scaled: x' = {spr_x[5:0], 0}, y' = {spr_y[4:0], 0}.
  - Each sprite bit is doubled horizontally, so the 8-bit byte becomes a 16-bit row.
  - Each source row is written to rows y'+2r and y'+2r+1 with the byte fetched once.
  - spr_n==0 in lores draws 16 rows of 8-wide bytes.
- Undefined: no lores port; the hi-res behaviour above only.

Decomposition:
- Package chip8_fb_pkg holds:
  - FB_ROWS=64, FB_WORDS_PER_ROW=8, FB_WORD_W=16, FB_AW.
  - The blitter state enum.
  - A helper for composing fbuf addresses.
- One sub-module, sprite_align: combinational row16 + x[3:0] (+ lores doubling) -> w0, w1, word indices and the clip flag.

Test Plan:
- Cleared FB, x=0, y=0, n=1, I=0x200, mem[0x200]=0xF0 -> addr 0 written 0xF000, addr 1 written 0x0000, collision=0, done in cycle 7.
- Repeat the same draw -> addr 0 = 0x0000, collision=1. A start during busy -> no extra fbuf access.
- x=12, byte 0xFF -> addr 0 = 0x000F, addr 1 = 0xF000. Then x=124, y=0 -> addr 7 = 0x000F and no access to addr 8.
- y=62, n=4 -> only addrs 496/497 and 504/505 accessed, then done; no access to rows 0-1.
- n=0, x=0, y=0, all bytes 0xFF -> 16 word-0 writes of 0xFFFF at addrs 0, 8, ..., 120; mem reads I..I+31.
- With SPRITE_BLITTER_LORES_EN: lores=1, x=1, y=1, byte 0x80 -> addrs 16 and 24 = 0x3000. Also rst_n=0 mid-draw -> next cycle busy=0, fbuf_en=0.

Source files
------------

// File: rtl/chip8_fb_pkg.sv
// Shared framebuffer geometry, blitter FSM state type and address helper for the Chip-8 display path.
package chip8_fb_pkg;

  localparam int unsigned FB_ROWS          = 64;
  localparam int unsigned FB_WORDS_PER_ROW = 8;
  localparam int unsigned FB_WORD_W        = 16;
  localparam int unsigned FB_AW            = 9;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StFwait,
    StFetch2,
    StFwait2,
    StRd0,
    StWr0,
    StRd1,
    StWr1,
    StDone
  } blit_state_e;

  // Word address of a framebuffer row/word pair: {row[5:0], word[2:0]}.
  function automatic logic [FB_AW-1:0] fb_addr(input logic [5:0] row, input logic [2:0] word);
    return {row, word};
  endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Sprite-memory read port and framebuffer CPU port as seen by the sprite blitter.
interface sprite_blitter_if #(
  parameter int unsigned MEM_AW = 12,
  parameter int unsigned FB_AW  = 9
);
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic              fbuf_en;
  logic              fbuf_write;
  logic [FB_AW-1:0]  fbuf_addr;
  logic [15:0]       fbuf_in;
  logic [15:0]       fbuf_out;

  modport master (
    output mem_addr, mem_rd, fbuf_en, fbuf_write, fbuf_addr, fbuf_in,
    input  mem_data, fbuf_out
  );

  modport slave (
    input  mem_addr, mem_rd, fbuf_en, fbuf_write, fbuf_addr, fbuf_in,
    output mem_data, fbuf_out
  );
endinterface

// File: rtl/sprite_align.sv
// Combinational sprite row alignment: builds the 16-bit row (optionally pixel-doubled) and splits
// it across the two framebuffer words it touches; clip_o flags a word 1 past the right edge.
module sprite_align
  import chip8_fb_pkg::*;
(
  input  logic [7:0]           hi_i,
  input  logic [7:0]           lo_i,
  input  logic                 wide_i,
  input  logic                 lores_i,
  input  logic [6:0]           x_i,
  output logic [FB_WORD_W-1:0] w0_o,
  output logic [FB_WORD_W-1:0] w1_o,
  output logic [2:0]           word0_o,
  output logic [2:0]           word1_o,
  output logic                 clip_o
);

  logic [FB_WORD_W-1:0]   row16;
  logic [2*FB_WORD_W-1:0] pat32;

  always_comb begin
    row16 = wide_i ? {hi_i, lo_i} : {hi_i, 8'h00};
    if (lores_i) begin
      for (int i = 0; i < 8; i++) begin
        row16[2*i]   = hi_i[i];
        row16[2*i+1] = hi_i[i];
      end
    end
    pat32 = {row16, 16'h0000} >> x_i[3:0];
  end

  assign w0_o    = pat32[31:16];
  assign w1_o    = pat32[15:0];
  assign word0_o = x_i[6:4];
  assign word1_o = x_i[6:4] + 3'd1;
  assign clip_o  = (x_i[6:4] == 3'd7);

endmodule

// File: rtl/sprite_blitter.sv
// Chip-8/SCHIP DXYN sprite blitter: fetches sprite rows and XORs them into the 128x64 framebuffer.
// Low-res (doubled) drawing is built in when SPRITE_BLITTER_LORES_EN is defined.
module sprite_blitter
  import chip8_fb_pkg::*;
#(
  parameter int unsigned MEM_AW = 12,
  parameter int unsigned FB_AW  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [6:0]        spr_x,
  input  logic [5:0]        spr_y,
  input  logic [3:0]        spr_n,
  input  logic [MEM_AW-1:0] spr_i,
`ifdef SPRITE_BLITTER_LORES_EN
  input  logic              lores,
`endif
  output logic              busy,
  output logic              done,
  output logic              collision,
  sprite_blitter_if.master  bus
);

  blit_state_e          state_q, state_d;
  logic [MEM_AW-1:0]    base_q, base_d, mem_addr_q, fetch_addr;
  logic [6:0]           x_q, x_d, row_q, row_d, row_nxt;
  logic [4:0]           rows_q, rows_d, src_q, src_d, src_nxt;
  logic                 wide_q, wide_d, lores_q, lores_d, dbl_q, dbl_d, coll_q, coll_d;
  logic [7:0]           hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, done_q, mem_rd_q, fbuf_en_q, fbuf_write_q;
  logic [FB_AW-1:0]     fbuf_addr_q;
  logic [FB_WORD_W-1:0] w0, w1, wdata;
  logic [2:0]           word0, word1;
  logic                 clip, adv, lores_in, fbuf_en_d;

`ifdef SPRITE_BLITTER_LORES_EN
  assign lores_in = lores;
`else
  assign lores_in = 1'b0;
`endif

  sprite_align u_align (
    .hi_i    (hi_q),
    .lo_i    (lo_q),
    .wide_i  (wide_q),
    .lores_i (lores_q),
    .x_i     (x_q),
    .w0_o    (w0),
    .w1_o    (w1),
    .word0_o (word0),
    .word1_o (word1),
    .clip_o  (clip)
  );

  // row_q is 7 bits so that stepping past row 63 is visible in bit 6.
  assign row_nxt = row_q + 7'd1;
  assign src_nxt = src_q + 5'd1;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    x_d     = x_q;
    row_d   = row_q;
    rows_d  = rows_q;
    src_d   = src_q;
    wide_d  = wide_q;
    lores_d = lores_q;
    dbl_d   = dbl_q;
    coll_d  = coll_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    adv     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          lores_d = lores_in;
          base_d  = spr_i;
          x_d     = lores_in ? {spr_x[5:0], 1'b0} : spr_x;
          row_d   = {1'b0, (lores_in ? {spr_y[4:0], 1'b0} : spr_y)};
          rows_d  = (spr_n == 4'd0) ? 5'd16 : {1'b0, spr_n};
          wide_d  = (spr_n == 4'd0) && !lores_in;
          src_d   = 5'd0;
          dbl_d   = 1'b0;
          coll_d  = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch:  state_d = StFwait;
      StFwait: begin
        hi_d    = bus.mem_data;
        state_d = wide_q ? StFetch2 : StRd0;
      end
      StFetch2: state_d = StFwait2;
      StFwait2: begin
        lo_d    = bus.mem_data;
        state_d = StRd0;
      end
      StRd0:    state_d = StWr0;
      StWr0: begin
        coll_d = coll_q | (|(bus.fbuf_out & w0));
        if (clip) adv = 1'b1;
        else      state_d = StRd1;
      end
      StRd1:    state_d = StWr1;
      StWr1: begin
        coll_d = coll_q | (|(bus.fbuf_out & w1));
        adv    = 1'b1;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (adv) begin
      row_d = row_nxt;
      // Low-res rows are drawn twice from one fetched byte.
      if (lores_q && !dbl_q) begin
        dbl_d   = 1'b1;
        state_d = row_nxt[6] ? StDone : StRd0;
      end else begin
        dbl_d   = 1'b0;
        src_d   = src_nxt;
        state_d = (src_nxt == rows_q || row_nxt[6]) ? StDone : StFetch;
      end
    end
  end

  always_comb begin
    fetch_addr = base_d + MEM_AW'(wide_d ? {src_d, 1'b0} : {1'b0, src_d});
    if (state_d == StFetch2) fetch_addr = fetch_addr + MEM_AW'(1);
    fbuf_en_d = state_d inside {StRd0, StWr0, StRd1, StWr1};
    // Write data must use this cycle's read result, so it cannot be registered.
    wdata = '0;
    if (state_q == StWr0)      wdata = bus.fbuf_out ^ w0;
    else if (state_q == StWr1) wdata = bus.fbuf_out ^ w1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      base_q       <= '0;
      x_q          <= '0;
      row_q        <= '0;
      rows_q       <= '0;
      src_q        <= '0;
      wide_q       <= 1'b0;
      lores_q      <= 1'b0;
      dbl_q        <= 1'b0;
      coll_q       <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      fbuf_en_q    <= 1'b0;
      fbuf_write_q <= 1'b0;
      fbuf_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      x_q          <= x_d;
      row_q        <= row_d;
      rows_q       <= rows_d;
      src_q        <= src_d;
      wide_q       <= wide_d;
      lores_q      <= lores_d;
      dbl_q        <= dbl_d;
      coll_q       <= coll_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      busy_q       <= !(state_d inside {StIdle, StDone});
      done_q       <= (state_d == StDone);
      mem_rd_q     <= state_d inside {StFetch, StFetch2};
      fbuf_en_q    <= fbuf_en_d;
      fbuf_write_q <= state_d inside {StWr0, StWr1};
      if (state_d inside {StFetch, StFetch2}) mem_addr_q <= fetch_addr;
      if (fbuf_en_d) begin
        fbuf_addr_q <= fb_addr(row_d[5:0], (state_d inside {StRd1, StWr1}) ? word1 : word0);
      end
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign collision      = coll_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.fbuf_en    = fbuf_en_q;
  assign bus.fbuf_write = fbuf_write_q;
  assign bus.fbuf_addr  = fbuf_addr_q;
  assign bus.fbuf_in    = wdata;

endmodule
